instruction_fetch_sequencer: RTL and testbench

Sequences the instruction ROM for the decryption core. It owns the program counter, drives the ROM address, and registers each fetched word into a single-entry output stage with a valid/ready handshake toward decode. It also handles start, jump redirect, halt-word detection and a count of delivered instructions. It sits between the control/jump logic and the asynchronous-read `InstructionRom`.

---
 rtl/instruction_fetch_sequencer_if.sv | 30 +++
 rtl/instruction_fetch_sequencer.sv | 83 ++++++++
 tb/tb_instruction_fetch_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, its control/jump logic, the instruction ROM and decode.
// The sequencer uses the slave modport; whatever drives it (controller + ROM + decode) uses master.
interface instruction_fetch_sequencer_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic                  start;
   logic [ADDR_WIDTH-1:0] start_address;
   logic                  jump_valid;
   logic [ADDR_WIDTH-1:0] jump_address;
   logic [ADDR_WIDTH-1:0] rom_address;
   logic [DATA_WIDTH-1:0] rom_data;
   logic [DATA_WIDTH-1:0] instr;
   logic [ADDR_WIDTH-1:0] instr_pc;
   logic                  instr_valid;
   logic                  instr_ready;
   logic                  busy;
   logic                  done;
   logic [15:0]           fetch_count;

   modport master (
      output start, start_address, jump_valid, jump_address, rom_data, instr_ready,
      input  rom_address, instr, instr_pc, instr_valid, busy, done, fetch_count
   );

   modport slave (
      input  start, start_address, jump_valid, jump_address, rom_data, instr_ready,
      output rom_address, instr, instr_pc, instr_valid, busy, done, fetch_count
   );
endinterface

// File: rtl/instruction_fetch_sequencer.sv
// Program counter + single-entry fetch output stage for the instruction ROM, with start,
// jump redirect, halt-word detection and a saturating count of delivered instructions.
module instruction_fetch_sequencer #(
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] HALT_WORD  = {DATA_WIDTH{1'b1}}
) (
   input logic                          clk,
   input logic                          rst,
   instruction_fetch_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] pc;
   logic [DATA_WIDTH-1:0] instr_q;
   logic [ADDR_WIDTH-1:0] instr_pc_q;
   logic                  instr_valid_q;
   logic                  busy_q;
   logic                  done_q;
   logic [15:0]           fetch_count_q;
   logic                  accept;
   logic                  slot_free;

   assign accept    = instr_valid_q & bus.instr_ready;
   assign slot_free = !instr_valid_q | accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         pc            <= '0;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         fetch_count_q <= '0;
      end else begin
         // Counted in any state; a start below overrides this with a clear.
         if (accept && fetch_count_q != 16'hFFFF)
            fetch_count_q <= fetch_count_q + 16'd1;

         case (state)
            FETCH: begin
               if (bus.jump_valid) begin
                  pc            <= bus.jump_address;
                  instr_valid_q <= 1'b0;
               end else if (slot_free) begin
                  if (bus.rom_data == HALT_WORD) begin
                     state         <= DONE;
                     busy_q        <= 1'b0;
                     done_q        <= 1'b1;
                     instr_valid_q <= 1'b0;
                  end else begin
                     instr_q       <= bus.rom_data;
                     instr_pc_q    <= pc;
                     instr_valid_q <= 1'b1;
                     pc            <= pc + ADDR_WIDTH'(1);
                  end
               end
            end
            default: begin
               if (bus.start) begin
                  state         <= FETCH;
                  busy_q        <= 1'b1;
                  done_q        <= 1'b0;
                  pc            <= bus.start_address;
                  instr_valid_q <= 1'b0;
                  fetch_count_q <= '0;
               end
            end
         endcase
      end
   end

   assign bus.rom_address = pc;
   assign bus.instr       = instr_q;
   assign bus.instr_pc    = instr_pc_q;
   assign bus.instr_valid = instr_valid_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.fetch_count = fetch_count_q;
endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Scoreboard bench: the monitor keeps a transaction-level model (queue of addresses still to be
// delivered, walked from the ROM image) and checks every accepted word and the status outputs.
module tb_instruction_fetch_sequencer;
  localparam int          AW   = 8;
  localparam int          DW   = 32;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam int M_IDLE = 0, M_FETCH = 1, M_DONE = 2;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] rom [256];

  instruction_fetch_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  instruction_fetch_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HALT_WORD(HALT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  assign bus.rom_data = rom[bus.rom_address];

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int q[$];          // addresses the program will still deliver, in order
  int ms = M_IDLE;
  int cnt = 0;
  logic pv, pr, pj;
  logic [31:0] pi;
  logic [7:0]  pp;

  function automatic void walk(input int a);
    int x;
    x = a;
    q.delete();
    for (int k = 0; k < 256; k++) begin
      if (rom[x[7:0]] == HALT) break;
      q.push_back(x);
      x = (x + 1) % 256;
    end
  endfunction

  always @(negedge clk) begin
    int a;
    logic jmp;
    if (rst) begin
      chk("rst_valid", 32'(bus.instr_valid), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_rom_address", 32'(bus.rom_address), 0);
      chk("rst_instr", bus.instr, 0);
      chk("rst_instr_pc", 32'(bus.instr_pc), 0);
      chk("rst_fetch_count", 32'(bus.fetch_count), 0);
      q.delete(); ms = M_IDLE; cnt = 0; pv = 1'b0;
    end else begin
      chk("busy", 32'(bus.busy), 32'(ms == M_FETCH));
      chk("done", 32'(bus.done), 32'(ms == M_DONE));
      chk("fetch_count", 32'(bus.fetch_count), cnt);
      if (ms != M_FETCH) chk("valid_outside_fetch", 32'(bus.instr_valid), 0);
      if (pv && !pr && !pj) begin
        chk("stall_valid", 32'(bus.instr_valid), 1);
        chk("stall_instr", bus.instr, pi);
        chk("stall_pc", 32'(bus.instr_pc), 32'(pp));
      end
      if (bus.instr_valid && bus.instr_ready) begin
        if (q.size() == 0) chk("unexpected_instr_pc", 32'(bus.instr_pc), 32'hDEAD);
        else begin
          a = q.pop_front();
          chk("instr_pc", 32'(bus.instr_pc), a);
          chk("instr", bus.instr, rom[a[7:0]]);
        end
        if (cnt < 65535) cnt++;
      end
      jmp = 1'b0;
      if (ms == M_FETCH) begin
        if (bus.jump_valid) begin jmp = 1'b1; walk(int'(bus.jump_address)); end
        else if (q.size() == 0) ms = M_DONE;
      end else if (bus.start) begin
        ms = M_FETCH; cnt = 0; walk(int'(bus.start_address));
      end
      pv = bus.instr_valid; pr = bus.instr_ready; pj = jmp;
      pi = bus.instr; pp = bus.instr_pc;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !bus.done; i++) cyc(1);
    chk("done_reached", 32'(bus.done), 1);
  endtask

  task automatic rom_basic();
    for (int i = 0; i < 256; i++) rom[i] = HALT;
    rom[8'h10] = 32'hA1; rom[8'h11] = 32'hA2; rom[8'h12] = 32'hA3;
  endtask

  task automatic pulse_start(input logic [7:0] sa);
    bus.start_address = sa; bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
  endtask

  initial begin
    logic [7:0] wexp [3];
    logic [31:0] w;
    rst = 1'b1;
    bus.start = 1'b0; bus.start_address = '0; bus.jump_valid = 1'b0;
    bus.jump_address = '0; bus.instr_ready = 1'b0;
    rom_basic();
    cyc(2);
    rst = 1'b0;
    cyc(1);

    // basic run: one word per cycle, then halt
    bus.instr_ready = 1'b1;
    pulse_start(8'h10);
    chk("start_busy", 32'(bus.busy), 1);
    chk("start_valid", 32'(bus.instr_valid), 0);
    chk("start_pc", 32'(bus.rom_address), 32'h10);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("basic_valid", 32'(bus.instr_valid), 1);
      chk("basic_pc", 32'(bus.instr_pc), 32'h10 + i);
    end
    cyc(1);
    chk("basic_done", 32'(bus.done), 1);
    chk("basic_count", 32'(bus.fetch_count), 3);
    chk("basic_valid_end", 32'(bus.instr_valid), 0);

    // backpressure: first word held for 4 cycles, no bubble on release
    bus.instr_ready = 1'b0;
    pulse_start(8'h10);
    cyc(1);
    repeat (4) begin
      chk("bp_instr", bus.instr, 32'hA1);
      chk("bp_pc", 32'(bus.instr_pc), 32'h10);
      cyc(1);
    end
    bus.instr_ready = 1'b1;
    cyc(1);
    chk("bp_release_valid", 32'(bus.instr_valid), 1);
    chk("bp_release_pc", 32'(bus.instr_pc), 32'h11);
    wait_done(20);
    chk("bp_count", 32'(bus.fetch_count), 3);

    // jump while 0x11 is accepted
    rom[8'h40] = 32'hB0;
    pulse_start(8'h10);
    cyc(2);
    chk("jmp_pre_pc", 32'(bus.instr_pc), 32'h11);
    bus.jump_valid = 1'b1; bus.jump_address = 8'h40;
    cyc(1);
    bus.jump_valid = 1'b0;
    chk("jmp_gap", 32'(bus.instr_valid), 0);
    chk("jmp_count", 32'(bus.fetch_count), 2);
    cyc(1);
    chk("jmp_valid", 32'(bus.instr_valid), 1);
    chk("jmp_instr", bus.instr, 32'hB0);
    chk("jmp_pc", 32'(bus.instr_pc), 32'h40);
    wait_done(20);
    chk("jmp_final_count", 32'(bus.fetch_count), 3);

    // wrap-around
    for (int i = 0; i < 256; i++) rom[i] = HALT;
    rom[8'hFE] = 32'hC0; rom[8'hFF] = 32'hC1; rom[8'h00] = 32'hC2;
    wexp[0] = 8'hFE; wexp[1] = 8'hFF; wexp[2] = 8'h00;
    pulse_start(8'hFE);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("wrap_pc", 32'(bus.instr_pc), 32'(wexp[i]));
    end
    cyc(1);
    chk("wrap_done", 32'(bus.done), 1);

    // ignored controls: start in FETCH, jump in DONE
    rom_basic();
    bus.instr_ready = 1'b0;
    pulse_start(8'h10);
    cyc(1);
    pulse_start(8'h80);
    chk("ign_start_pc", 32'(bus.rom_address), 32'h11);
    chk("ign_start_ipc", 32'(bus.instr_pc), 32'h10);
    chk("ign_start_busy", 32'(bus.busy), 1);
    bus.instr_ready = 1'b1;
    wait_done(20);
    bus.jump_valid = 1'b1; bus.jump_address = 8'h20;
    cyc(1);
    bus.jump_valid = 1'b0;
    chk("ign_jump_done", 32'(bus.done), 1);
    chk("ign_jump_pc", 32'(bus.rom_address), 32'h13);

    // asynchronous reset with a stalled word pending
    bus.instr_ready = 1'b0;
    pulse_start(8'h10);
    cyc(1);
    chk("pre_rst_valid", 32'(bus.instr_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(bus.instr_valid), 0);
    chk("async_rst_busy", 32'(bus.busy), 0);
    chk("async_rst_pc", 32'(bus.rom_address), 0);
    chk("async_rst_instr", bus.instr, 0);
    cyc(1);
    rst = 1'b0;
    bus.instr_ready = 1'b1;
    pulse_start(8'h10);
    wait_done(20);
    chk("post_rst_count", 32'(bus.fetch_count), 3);

    // randomized traffic over a random ROM image
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if (w == HALT) w = 32'h0;
      rom[i] = ($urandom_range(0, 5) == 0) ? HALT : w;
    end
    rom[$urandom_range(0, 255)] = HALT;
    repeat (3000) begin
      bus.instr_ready   = ($urandom_range(0, 3) != 0);
      bus.start         = ($urandom_range(0, 7) == 0);
      bus.start_address = 8'($urandom);
      bus.jump_valid    = ($urandom_range(0, 15) == 0);
      bus.jump_address  = 8'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
      end
      cyc(1);
    end

    bus.start = 1'b0; bus.jump_valid = 1'b0;
    cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
